// File: rtl/bucket_hash_table.sv
// Bucketed hash-join table: a build stream fills fixed-size rows, then a probe stream
// emits one joined beat per key match (or one miss beat) in slot order.
module bucket_hash_table #(
    parameter int ROW_BITS = 3,
    parameter int SLOTS    = 4,
    parameter int KEY_BITS = 32,
    parameter int TUPLE_W  = 64
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid_build,
    output logic                 in_ready_build,
    input  logic [TUPLE_W-1:0]   in_data_build,
    input  logic [31:0]          in_hash_build,
    input  logic                 in_last_build,
    input  logic                 in_valid_probe,
    output logic                 in_ready_probe,
    input  logic [TUPLE_W-1:0]   in_data_probe,
    input  logic [31:0]          in_hash_probe,
    input  logic [63:0]          in_serialnum,
    input  logic                 in_last_probe,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*TUPLE_W-1:0] out_data,
    output logic [63:0]          out_serialnum,
    output logic                 out_was_joined,
    output logic                 out_last,
    output logic [31:0]          overflow_cnt
);
    localparam int ROWS  = 1 << ROW_BITS;
    localparam int CNT_W = $clog2(SLOTS + 1);
    localparam int ROW_W = CNT_W + SLOTS * TUPLE_W;
    localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [CNT_W-1:0] SLOTS_C = CNT_W'(SLOTS);

    typedef enum logic [2:0] {INIT, B_IDLE, B_RMW, P_IDLE, P_RD, P_EMIT, DONE} state_t;

    state_t               state;
    logic [ROW_BITS-1:0]  init_row, row_q;
    logic [TUPLE_W-1:0]   tuple_q;
    logic [63:0]          serial_q;
    logic [ROW_W-1:0]     row_reg;
    logic [SLOTS-1:0]     m_rem;

    logic [ROW_W-1:0]     mem [ROWS];
    logic [ROW_W-1:0]     rd_data, wr_data, ins_row;
    logic [ROW_BITS-1:0]  rd_addr, wr_addr;
    logic                 rd_en, wr_en, build_fire, probe_fire;
    logic [CNT_W-1:0]     rd_cnt;
    logic [SLOTS-1:0]     m;
    logic                 unused_hash;

    assign unused_hash = ^{in_hash_build[31:ROW_BITS], in_hash_probe[31:ROW_BITS]};

    function automatic logic [IDX_W-1:0] lowest(input logic [SLOTS-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = SLOTS - 1; i >= 0; i--)
            if (v[i]) r = IDX_W'(i);
        return r;
    endfunction

    function automatic logic [TUPLE_W-1:0] slot_of(input logic [ROW_W-1:0] row,
                                                   input logic [IDX_W-1:0] idx);
        return row[int'(idx) * TUPLE_W +: TUPLE_W];
    endfunction

    // Simple dual-port row store, 1-cycle read latency.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

    assign build_fire = (state == B_IDLE) && in_valid_build;
    assign probe_fire = (state == P_IDLE) && in_valid_probe;
    assign rd_en      = build_fire || probe_fire;
    assign rd_addr    = build_fire ? in_hash_build[ROW_BITS-1:0] : in_hash_probe[ROW_BITS-1:0];
    assign rd_cnt     = rd_data[ROW_W-1 -: CNT_W];

    always_comb begin
        ins_row = rd_data;
        ins_row[ROW_W-1 -: CNT_W] = rd_cnt + CNT_W'(1);
        for (int i = 0; i < SLOTS; i++) begin
            if (rd_cnt == CNT_W'(i)) ins_row[i*TUPLE_W +: TUPLE_W] = tuple_q;
            m[i] = (CNT_W'(i) < rd_cnt) &&
                   (rd_data[i*TUPLE_W +: KEY_BITS] == tuple_q[KEY_BITS-1:0]);
        end
    end

    // Build RMW never collides with a read: the next read is issued a cycle after the write.
    assign wr_en   = resetn && ((state == INIT) || ((state == B_RMW) && (rd_cnt < SLOTS_C)));
    assign wr_addr = (state == INIT) ? init_row : row_q;
    assign wr_data = (state == INIT) ? '0 : ins_row;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= INIT;
            init_row       <= '0;
            row_q          <= '0;
            tuple_q        <= '0;
            serial_q       <= '0;
            row_reg        <= '0;
            m_rem          <= '0;
            in_ready_build <= 1'b0;
            in_ready_probe <= 1'b0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_serialnum  <= '0;
            out_was_joined <= 1'b0;
            out_last       <= 1'b0;
            overflow_cnt   <= '0;
        end else begin
            case (state)
                INIT: begin
                    init_row <= init_row + 1'b1;
                    if (init_row == ROW_BITS'(ROWS - 1)) begin
                        state          <= B_IDLE;
                        in_ready_build <= 1'b1;
                    end
                end
                B_IDLE: begin
                    if (in_valid_build) begin
                        tuple_q        <= in_data_build;
                        row_q          <= in_hash_build[ROW_BITS-1:0];
                        state          <= B_RMW;
                        in_ready_build <= 1'b0;
                    end else if (in_last_build) begin
                        state          <= P_IDLE;
                        in_ready_build <= 1'b0;
                        in_ready_probe <= 1'b1;
                    end
                end
                B_RMW: begin
                    if (rd_cnt == SLOTS_C && overflow_cnt != '1)
                        overflow_cnt <= overflow_cnt + 1'b1;
                    state          <= B_IDLE;
                    in_ready_build <= 1'b1;
                end
                P_IDLE: begin
                    if (in_valid_probe) begin
                        tuple_q        <= in_data_probe;
                        serial_q       <= in_serialnum;
                        state          <= P_RD;
                        in_ready_probe <= 1'b0;
                    end else if (in_last_probe) begin
                        state          <= DONE;
                        in_ready_probe <= 1'b0;
                        out_last       <= 1'b1;
                    end
                end
                P_RD: begin
                    row_reg       <= rd_data;
                    out_valid     <= 1'b1;
                    out_serialnum <= serial_q;
                    state         <= P_EMIT;
                    if (|m) begin
                        out_data       <= {slot_of(rd_data, lowest(m)), tuple_q};
                        out_was_joined <= 1'b1;
                        m_rem          <= m & (m - 1'b1);
                    end else begin
                        out_data       <= {{TUPLE_W{1'b0}}, tuple_q};
                        out_was_joined <= 1'b0;
                        m_rem          <= '0;
                    end
                end
                P_EMIT: begin
                    if (out_ready) begin
                        if (|m_rem) begin
                            out_data <= {slot_of(row_reg, lowest(m_rem)), tuple_q};
                            m_rem    <= m_rem & (m_rem - 1'b1);
                        end else begin
                            out_valid      <= 1'b0;
                            state          <= P_IDLE;
                            in_ready_probe <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
